// File: rtl/fft8_pkg.sv
// ----------------------------------------------------------------------------
// fft8_pkg
// Shared definitions for the 8-point FFT frame controller: sample widths,
// slot packing of the parallel datapath bus, FSM state encoding and the
// 3-bit bit-reversal used to place samples in DIT input order.
// ----------------------------------------------------------------------------
package fft8_pkg;

    localparam int DW   = 16;        // real/imag width
    localparam int NPT  = 8;         // FFT points / buffer slots
    localparam int SW   = 2 * DW;    // one complex slot
    localparam int BUSW = NPT * SW;  // full parallel bus

    // Slot layout on the parallel bus: real part in the upper DW bits.
    typedef struct packed {
        logic [DW-1:0] re;
        logic [DW-1:0] im;
    } cplx_t;

    localparam logic [1:0] ST_LOAD   = 2'd0;
    localparam logic [1:0] ST_RUN    = 2'd1;
    localparam logic [1:0] ST_UNLOAD = 2'd2;

    // Lowest bit of slot j on the parallel bus.
    function automatic int slot_lo(input int j);
        return j * SW;
    endfunction

    function automatic logic [2:0] bitrev3(input logic [2:0] idx);
        return {idx[0], idx[1], idx[2]};
    endfunction

endpackage

// File: rtl/fft8_frame_ctrl_if.sv
// ----------------------------------------------------------------------------
// fft8_frame_ctrl_if
// Sample-in / bin-out streaming handshakes of the FFT frame controller.
//   s_valid/s_ready/s_re/s_im : serial input samples
//   m_valid/m_ready/m_re/m_im/m_last : serial output bins
// master : the environment (sample source and bin sink)
// slave  : the controller
// ----------------------------------------------------------------------------
interface fft8_frame_ctrl_if;
    import fft8_pkg::*;

    logic          s_valid;
    logic          s_ready;
    logic [DW-1:0] s_re;
    logic [DW-1:0] s_im;

    logic          m_valid;
    logic          m_ready;
    logic [DW-1:0] m_re;
    logic [DW-1:0] m_im;
    logic          m_last;

    modport master (
        output s_valid, s_re, s_im, m_ready,
        input  s_ready, m_valid, m_re, m_im, m_last
    );

    modport slave (
        input  s_valid, s_re, s_im, m_ready,
        output s_ready, m_valid, m_re, m_im, m_last
    );

endinterface

// File: rtl/fft8_frame_buf.sv
// ----------------------------------------------------------------------------
// fft8_frame_buf
// 8 x (2*DW) register file with one indexed write port, a whole-buffer
// parallel load port and a parallel read bus in datapath packing.
//   clk, rst      : clock, async active-low reset (clears all slots)
//   we/waddr/wdata: single-slot write
//   ld/ld_data    : load all slots at once (has priority over we)
//   rd_bus        : all slots, slot j at bits [SW*j +: SW]
// ----------------------------------------------------------------------------
module fft8_frame_buf
    import fft8_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            we,
    input  logic [2:0]      waddr,
    input  logic [SW-1:0]   wdata,
    input  logic            ld,
    input  logic [BUSW-1:0] ld_data,
    output logic [BUSW-1:0] rd_bus
);

    logic [SW-1:0] r_mem [NPT];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int j = 0; j < NPT; j++) begin
                r_mem[j] <= '0;
            end
        end else if (ld) begin
            for (int j = 0; j < NPT; j++) begin
                r_mem[j] <= ld_data[slot_lo(j) +: SW];
            end
        end else if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    for (genvar g = 0; g < NPT; g++) begin : g_rd
        assign rd_bus[slot_lo(g) +: SW] = r_mem[g];
    end

endmodule

// File: rtl/fft8_frame_ctrl.sv
// ----------------------------------------------------------------------------
// fft8_frame_ctrl
// Frame sequencer for an 8-point radix-2 DIT FFT datapath. Collects 8 serial
// samples into bit-reversed slots, fires the datapath, waits PIPE_LAT cycles,
// captures the result and streams the 8 bins out in natural order.
//
//   state  | meaning
//   -------+-------------------------------------------------------------
//   LOAD   | accepting samples, s_ready=1
//   RUN    | fft_x frozen, fft_go on first cycle, waiting out pipeline
//   UNLOAD | presenting bins 0..7 with m_valid=1, honours backpressure
//
// Ports:
//   clk, rst   : clock, async active-low reset
//   bus        : sample-in / bin-out handshakes (slave modport)
//   fft_x      : parallel datapath input (input buffer contents)
//   fft_go     : one-cycle pulse, fft_x complete
//   fft_y      : parallel datapath output
//   busy       : frame in progress
//   frame_cnt  : completed frames, wraps at 256
// ----------------------------------------------------------------------------
module fft8_frame_ctrl
    import fft8_pkg::*;
#(
    parameter int PIPE_LAT = 3  // 1..15
) (
    input  logic             clk,
    input  logic             rst,
    fft8_frame_ctrl_if.slave bus,
    output logic [BUSW-1:0]  fft_x,
    output logic             fft_go,
    input  logic [BUSW-1:0]  fft_y,
    output logic             busy,
    output logic [7:0]       frame_cnt
);

    localparam logic [3:0] LAT_TC = 4'(PIPE_LAT);

    logic [1:0]      r_state;
    logic [2:0]      r_ld_cnt;
    logic [2:0]      r_ul_cnt;
    logic [3:0]      r_wait_cnt;
    logic [7:0]      r_frame_cnt;
    logic            r_fft_go;

    logic            w_s_hs;
    logic            w_m_hs;
    logic            w_load_done;
    logic            w_last_bin;
    logic            w_capture;
    logic [SW-1:0]   w_s_sample;
    logic [BUSW-1:0] w_out_bus;
    cplx_t           w_out_slot [NPT];
    cplx_t           w_bin;

    // Handshakes only exist in the state that owns them, so s_valid is
    // ignored outside LOAD and m_ready is ignored outside UNLOAD.
    assign w_s_hs      = (r_state == ST_LOAD) && bus.s_valid;
    assign w_m_hs      = (r_state == ST_UNLOAD) && bus.m_ready;
    assign w_load_done = w_s_hs && (r_ld_cnt == 3'd7);
    assign w_last_bin  = w_m_hs && (r_ul_cnt == 3'd7);
    assign w_capture   = (r_state == ST_RUN) && (r_wait_cnt == LAT_TC);

    assign w_s_sample  = {bus.s_re, bus.s_im};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= ST_LOAD;
            r_ld_cnt    <= '0;
            r_ul_cnt    <= '0;
            r_wait_cnt  <= '0;
            r_frame_cnt <= '0;
            r_fft_go    <= 1'b0;
        end else begin
            // First RUN cycle is the cycle right after the 8th handshake.
            r_fft_go <= w_load_done;
            case (r_state)
                ST_LOAD: begin
                    if (w_s_hs) begin
                        r_ld_cnt <= r_ld_cnt + 3'd1;
                    end
                    if (w_load_done) begin
                        r_wait_cnt <= '0;
                        r_state    <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    r_wait_cnt <= r_wait_cnt + 4'd1;
                    if (w_capture) begin
                        r_state <= ST_UNLOAD;
                    end
                end
                ST_UNLOAD: begin
                    if (w_m_hs) begin
                        r_ul_cnt <= r_ul_cnt + 3'd1;
                    end
                    if (w_last_bin) begin
                        r_frame_cnt <= r_frame_cnt + 8'd1;
                        r_state     <= ST_LOAD;
                    end
                end
                default: begin
                    r_state <= ST_LOAD;
                end
            endcase
        end
    end

    // Input buffer: samples land in bit-reversed slots so the DIT datapath
    // can produce bins in natural order. Writes stop outside LOAD, which
    // keeps fft_x frozen through RUN.
    fft8_frame_buf u_in_buf (
        .clk     (clk),
        .rst     (rst),
        .we      (w_s_hs),
        .waddr   (bitrev3(r_ld_cnt)),
        .wdata   (w_s_sample),
        .ld      (1'b0),
        .ld_data ('0),
        .rd_bus  (fft_x)
    );

    // Output buffer: snapshot of fft_y taken when the pipeline has settled,
    // so the datapath is free to change while bins drain.
    fft8_frame_buf u_out_buf (
        .clk     (clk),
        .rst     (rst),
        .we      (1'b0),
        .waddr   (3'd0),
        .wdata   ('0),
        .ld      (w_capture),
        .ld_data (fft_y),
        .rd_bus  (w_out_bus)
    );

    for (genvar g = 0; g < NPT; g++) begin : g_slot
        assign w_out_slot[g] = w_out_bus[slot_lo(g) +: SW];
    end

    assign w_bin       = w_out_slot[r_ul_cnt];

    assign bus.s_ready = (r_state == ST_LOAD);
    assign bus.m_valid = (r_state == ST_UNLOAD);
    assign bus.m_re    = w_bin.re;
    assign bus.m_im    = w_bin.im;
    assign bus.m_last  = (r_state == ST_UNLOAD) && (r_ul_cnt == 3'd7);

    assign fft_go      = r_fft_go;
    assign busy        = (r_state != ST_LOAD) || (r_ld_cnt != 3'd0);
    assign frame_cnt   = r_frame_cnt;

endmodule

// File: tb/tb_fft8_frame_ctrl.sv
// ----------------------------------------------------------------------------
// tb_fft8_frame_ctrl
// Directed bench for fft8_frame_ctrl with a behavioural 3-stage datapath
// (identity delay line or radix-2 DIT butterflies).
// ----------------------------------------------------------------------------
module tb_fft8_frame_ctrl;

    localparam int PIPE_LAT = 3;
    localparam int BW       = 256;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    fft8_frame_ctrl_if bus();

    logic [BW-1:0] fft_x;
    logic [BW-1:0] fft_y;
    logic          fft_go;
    logic          busy;
    logic [7:0]    frame_cnt;

    fft8_frame_ctrl #(.PIPE_LAT(PIPE_LAT)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .fft_x     (fft_x),
        .fft_go    (fft_go),
        .fft_y     (fft_y),
        .busy      (busy),
        .frame_cnt (frame_cnt)
    );

    // ---------------- datapath model ----------------
    int tw_re [4] = '{256, 181, 0, -181};
    int tw_im [4] = '{0, -181, -256, -181};

    function automatic logic [BW-1:0] bfly(input logic [BW-1:0] x, input int s);
        logic [BW-1:0] y;
        int span, k, ar, ai, br, bi, tr, ti;
        y    = x;
        span = 1 << s;
        for (int i = 0; i < 8; i++) begin
            if ((i & span) == 0) begin
                ar = $signed(x[i*32+16 +: 16]);
                ai = $signed(x[i*32 +: 16]);
                br = $signed(x[(i+span)*32+16 +: 16]);
                bi = $signed(x[(i+span)*32 +: 16]);
                k  = (i % span) * (4 / span);
                tr = (br * tw_re[k] - bi * tw_im[k]) >>> 8;
                ti = (br * tw_im[k] + bi * tw_re[k]) >>> 8;
                y[i*32+16 +: 16]        = 16'(ar + tr);
                y[i*32 +: 16]           = 16'(ai + ti);
                y[(i+span)*32+16 +: 16] = 16'(ar - tr);
                y[(i+span)*32 +: 16]    = 16'(ai - ti);
            end
        end
        return y;
    endfunction

    logic          dft_mode = 1'b0;
    logic [BW-1:0] p1 = '0, p2 = '0, p3 = '0;
    always @(posedge clk) begin
        p1 <= dft_mode ? bfly(fft_x, 0) : fft_x;
        p2 <= dft_mode ? bfly(p1, 1) : p1;
        p3 <= dft_mode ? bfly(p2, 2) : p2;
    end
    assign fft_y = p3;

    // ---------------- checking ----------------
    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- monitor ----------------
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [15:0] q_re [$];
    logic [15:0] q_im [$];
    logic        q_last [$];
    int          go_cnt = 0, go_cyc = -1, in_hs = 0, last_in_cyc = -1;
    int          first_mv_cyc = -1, chk_ready_at = -1;
    logic        prev_stall = 1'b0, prev_last = 1'b0;
    logic [15:0] prev_re = '0, prev_im = '0;

    initial forever begin
        @(negedge clk);
        if (!rst) begin
            prev_stall   = 1'b0;
            chk_ready_at = -1;
        end else begin
            if (prev_stall) begin
                check("stall_valid", bus.m_valid, 1'b1);
                check("stall_re", bus.m_re, prev_re);
                check("stall_im", bus.m_im, prev_im);
                check("stall_last", bus.m_last, prev_last);
            end
            if (chk_ready_at == cyc) begin
                check("sready_after_last", bus.s_ready, 1'b1);
                check("mvalid_after_last", bus.m_valid, 1'b0);
                chk_ready_at = -1;
            end
            if (bus.m_valid) check("sready_in_unload", bus.s_ready, 1'b0);
            if (cyc == last_in_cyc && in_hs == 8) check("sready_drop", bus.s_ready, 1'b0);
            if (fft_go) begin
                go_cnt++;
                go_cyc = cyc;
            end
            if (bus.m_valid && first_mv_cyc < 0) first_mv_cyc = cyc;
            if (bus.s_valid && bus.s_ready) begin
                in_hs++;
                last_in_cyc = cyc + 1;
            end
            if (bus.m_valid && bus.m_ready) begin
                q_re.push_back(bus.m_re);
                q_im.push_back(bus.m_im);
                q_last.push_back(bus.m_last);
                if (bus.m_last) chk_ready_at = cyc + 1;
            end
            prev_stall = bus.m_valid && !bus.m_ready;
            prev_re    = bus.m_re;
            prev_im    = bus.m_im;
            prev_last  = bus.m_last;
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    int          ord [8] = '{0, 4, 2, 6, 1, 5, 3, 7};
    logic [15:0] tx_re [8], tx_im [8], exp_re [8], exp_im [8];

    task automatic set_identity(input int base);
        for (int k = 0; k < 8; k++) begin
            tx_re[k] = 16'(base + k);
            tx_im[k] = 16'(-(base + k));
        end
        for (int j = 0; j < 8; j++) begin
            exp_re[j] = tx_re[ord[j]];
            exp_im[j] = tx_im[ord[j]];
        end
    endtask

    task automatic send_frame(input int n, input int gaps, input int junk);
        logic got;
        for (int k = 0; k < n; k++) begin
            if (gaps != 0) begin
                bus.s_valid = 1'b0;
                repeat ($urandom_range(0, 3)) begin
                    @(posedge clk); #1;
                end
            end
            bus.s_valid = 1'b1;
            bus.s_re    = tx_re[k];
            bus.s_im    = tx_im[k];
            got = 1'b0;
            for (int t = 0; t < 200 && !got; t++) begin
                @(negedge clk);
                got = bus.s_ready;
                @(posedge clk); #1;
            end
            if (!got) check("send_timeout", 1'b0, 1'b1);
        end
        bus.s_valid = 1'b0;
        if (junk != 0) begin
            bus.s_valid = 1'b1;
            bus.s_re    = 16'hdead;
            bus.s_im    = 16'hbeef;
            got = 1'b0;
            for (int t = 0; t < 100 && !got; t++) begin
                @(negedge clk);
                got = bus.m_valid;
            end
            @(posedge clk); #1;
            bus.s_valid = 1'b0;
        end
    endtask

    task automatic recv_frame(input int pat);
        logic done;
        done = 1'b0;
        for (int t = 0; t < 400 && !done; t++) begin
            if (pat == 1) bus.m_ready = (t % 4 == 0) || (t % 4 == 3);
            else          bus.m_ready = 1'b1;
            @(posedge clk); #1;
            done = (q_re.size() >= 8);
        end
        bus.m_ready = 1'b0;
        if (!done) check("recv_timeout", 1'b0, 1'b1);
    endtask

    task automatic run_frame(input int gaps, input int junk, input int pat);
        q_re.delete();
        q_im.delete();
        q_last.delete();
        go_cnt = 0; go_cyc = -1; in_hs = 0; last_in_cyc = -1; first_mv_cyc = -1;
        fork
            send_frame(8, gaps, junk);
            recv_frame(pat);
        join
        @(negedge clk);
        @(posedge clk); #1;
    endtask

    task automatic check_bins(input string tag);
        logic exp_last;
        check($sformatf("%s_count", tag), q_re.size(), 8);
        for (int j = 0; j < 8 && j < q_re.size(); j++) begin
            exp_last = (j == 7);
            check($sformatf("%s_re%0d", tag, j), q_re[j], exp_re[j]);
            check($sformatf("%s_im%0d", tag, j), q_im[j], exp_im[j]);
            check($sformatf("%s_last%0d", tag, j), q_last[j], exp_last);
        end
    endtask

    task automatic apply_reset();
        rst = 1'b0;
        bus.s_valid = 1'b0;
        bus.m_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_s_ready"}, bus.s_ready, 1'b1);
        check({tag, "_m_valid"}, bus.m_valid, 1'b0);
        check({tag, "_m_last"}, bus.m_last, 1'b0);
        check({tag, "_fft_go"}, fft_go, 1'b0);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_frame_cnt"}, frame_cnt, 8'd0);
        check({tag, "_fft_x_nz"}, |fft_x, 1'b0);
    endtask

    initial begin
        bus.s_valid = 1'b0;
        bus.s_re    = '0;
        bus.s_im    = '0;
        bus.m_ready = 1'b0;

        // 1: ordering through identity pipeline
        apply_reset();
        @(negedge clk);
        check_reset_values("rst");
        @(posedge clk); #1;
        set_identity(0);
        run_frame(0, 0, 0);
        check_bins("order");
        check("s1_go_count", go_cnt, 1);
        check("s1_go_timing", go_cyc, last_in_cyc);
        check("s1_capture_timing", first_mv_cyc, go_cyc + PIPE_LAT + 1);
        check("s1_in_hs", in_hs, 8);
        check("s1_frame_cnt", frame_cnt, 8'd1);

        // 2: impulse through DIT butterflies
        apply_reset();
        dft_mode = 1'b1;
        for (int k = 0; k < 8; k++) begin
            tx_re[k]  = (k == 0) ? 16'd1000 : 16'd0;
            tx_im[k]  = 16'd0;
            exp_re[k] = 16'd1000;
            exp_im[k] = 16'd0;
        end
        check("s2_frame_cnt_pre", frame_cnt, 8'd0);
        run_frame(0, 0, 0);
        check_bins("impulse");
        check("s2_frame_cnt", frame_cnt, 8'd1);
        dft_mode = 1'b0;

        // 3: backpressure 1,0,0,1
        for (int k = 0; k < 8; k++) begin
            tx_re[k] = 16'(1000 + 11 * k);
            tx_im[k] = 16'(-500 - k);
        end
        for (int j = 0; j < 8; j++) begin
            exp_re[j] = tx_re[ord[j]];
            exp_im[j] = tx_im[ord[j]];
        end
        run_frame(0, 0, 1);
        check_bins("bp");
        check("s3_go_count", go_cnt, 1);
        check("s3_frame_cnt", frame_cnt, 8'd2);

        // 4: input gaps plus stray samples during RUN/UNLOAD
        set_identity(0);
        run_frame(1, 1, 0);
        check_bins("gaps");
        check("s4_in_hs", in_hs, 8);
        check("s4_frame_cnt", frame_cnt, 8'd3);

        // 5: reset after 5 samples
        for (int k = 0; k < 8; k++) begin
            tx_re[k] = 16'h0aa0 + 16'(k);
            tx_im[k] = 16'h0550 + 16'(k);
        end
        send_frame(5, 0, 0);
        @(negedge clk);
        check("s5_busy_partial", busy, 1'b1);
        @(posedge clk); #1;
        rst = 1'b0;
        #2;
        check_reset_values("midrst");
        @(posedge clk); #1;
        rst = 1'b1;
        set_identity(50);
        run_frame(0, 0, 0);
        check_bins("after_rst");
        check("s5_frame_cnt", frame_cnt, 8'd1);

        // 6: 256 frames, frame_cnt wraps
        apply_reset();
        for (int f = 0; f < 256; f++) begin
            set_identity(f * 8);
            run_frame(0, 0, 0);
            check_bins($sformatf("wrap%0d", f));
            if (f == 254) check("s6_frame_cnt_255", frame_cnt, 8'd255);
        end
        check("s6_frame_cnt_wrap", frame_cnt, 8'd0);
        check("s6_busy_idle", busy, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
